// File: rtl/ysyx_23060124_lsu_bus.sv
// Load/store unit bridging EX to a single-outstanding valid/ready data bus.
// Aligns store lanes, extends load data, and reports misalign/bus/timeout errors.
`timescale 1ns/1ps
module ysyx_23060124_lsu_bus #(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_we,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [AW-1:0]     i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [AW-1:0]     o_mem_addr,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_wstrb,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata,
    input  logic              i_mem_err,
    output logic              o_done,
    output logic [XLEN-1:0]   o_rdata,
    output logic [1:0]        o_err
);

    localparam int SW   = XLEN / 8;
    localparam int OFFW = $clog2(SW);
    localparam int CW   = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_BUS   = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    function automatic logic misaligned(input logic [1:0] size, input logic [OFFW-1:0] off);
        logic [3:0] off_w;
        logic [3:0] mask;
        off_w = 4'(off);
        mask  = (4'd1 << size) - 4'd1;
        return ((off_w & mask) != 4'd0) || ((size == 2'd3) && (XLEN == 32));
    endfunction

    function automatic logic [SW-1:0] lane_strobe(input logic [1:0] size, input logic [OFFW-1:0] off);
        logic [15:0] len;
        logic [15:0] shifted;
        case (size)
            2'd0:    len = 16'h0001;
            2'd1:    len = 16'h0003;
            2'd2:    len = 16'h000F;
            default: len = 16'h00FF;
        endcase
        shifted = len << off;
        return shifted[SW-1:0];
    endfunction

    function automatic logic [XLEN-1:0] lane_data(input logic [XLEN-1:0] data, input logic [OFFW-1:0] off);
        return data << {off, 3'b000};
    endfunction

    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0] data,
        input logic [1:0]      size,
        input logic            uns,
        input logic [OFFW-1:0] off
    );
        logic [XLEN-1:0]    r;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        r = data >> {off, 3'b000};
        b = r[7:0];
        h = r[15:0];
        w = r[31:0];
        case (size)
            2'd0:    load_extract = uns ? XLEN'(r[7:0])  : XLEN'(b);
            2'd1:    load_extract = uns ? XLEN'(r[15:0]) : XLEN'(h);
            2'd2:    load_extract = uns ? XLEN'(r[31:0]) : XLEN'(w);
            default: load_extract = r;
        endcase
    endfunction

    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [OFFW-1:0] off_q;
    logic [AW-1:0]   mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [SW-1:0]   mem_wstrb_q;
    logic [XLEN-1:0] rdata_q;
    logic [1:0]      err_q;
    logic [CW-1:0]   cnt_q;

    logic [OFFW-1:0] in_off;
    logic            in_mis;
    logic            cnt_last;
    logic            accept;

    assign in_off   = i_addr[OFFW-1:0];
    assign in_mis   = misaligned(i_size, in_off);
    assign cnt_last = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        o_ready     = 1'b0;
        o_mem_valid = 1'b0;
        o_done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept  = 1'b1;
                    state_d = in_mis ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                o_mem_valid = 1'b1;
                if (i_mem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_mem_rvalid || cnt_last) state_d = S_DONE;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture at accept; fields then stay frozen through REQ/WAIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else if (accept) begin
            we_q        <= i_we;
            size_q      <= i_size;
            uns_q       <= i_unsigned;
            off_q       <= in_off;
            mem_addr_q  <= {i_addr[AW-1:OFFW], {OFFW{1'b0}}};
            mem_wdata_q <= lane_data(i_wdata, in_off);
            mem_wstrb_q <= i_we ? lane_strobe(i_size, in_off) : '0;
        end
    end

    // Response/timeout handling; results only change on the way into DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && in_mis) begin
                        rdata_q <= '0;
                        err_q   <= ERR_ALIGN;
                    end
                end
                S_REQ: begin
                    if (i_mem_ready) cnt_q <= '0;
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        err_q   <= i_mem_err ? ERR_BUS : ERR_OK;
                        rdata_q <= (i_mem_err || we_q) ? '0
                                   : load_extract(i_mem_rdata, size_q, uns_q, off_q);
                    end else if (cnt_last) begin
                        err_q   <= ERR_TMO;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_addr  = mem_addr_q;
    assign o_mem_we    = we_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_wstrb = mem_wstrb_q;
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_ysyx_23060124_lsu_bus.sv
// Directed bench for ysyx_23060124_lsu_bus (XLEN=32, TIMEOUT=4) with an
// arithmetic reference model and a per-cycle output checker.
`timescale 1ns/1ps
module tb_ysyx_23060124_lsu_bus;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_we = 1'b0;
    logic [1:0]  i_size = 2'd0;
    logic        i_unsigned = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        o_mem_valid;
    logic        i_mem_ready = 1'b0;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        i_mem_err = 1'b0;
    logic        o_done;
    logic [31:0] o_rdata;
    logic [1:0]  o_err;

    ysyx_23060124_lsu_bus #(.XLEN(32), .AW(32), .TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_we(i_we), .i_size(i_size), .i_unsigned(i_unsigned), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .o_mem_wstrb(o_mem_wstrb), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .i_mem_err(i_mem_err), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic armed = 1'b0;
    logic bus_ok = 1'b0;
    logic prev_done = 1'b0;

    logic [31:0] exp_addr, exp_wdata, cur_rdata, hold_rdata;
    logic [3:0]  exp_wstrb;
    logic        exp_we;
    logic [1:0]  cur_err, hold_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference model: plain byte arithmetic on a 32-bit bus.
    function automatic logic m_mis(input logic [1:0] size, input logic [31:0] a);
        int n;
        n = 1 << size;
        return (size == 2'd3) || ((a % n) != 0);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [31:0] a);
        logic [63:0] v;
        v = {32'b0, d} << (8 * (a % 4));
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [1:0] size, input logic [31:0] a);
        logic [31:0] s;
        int n;
        n = 1 << size;
        s = ((32'd1 << n) - 32'd1) << (a % 4);
        return s[3:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] d, input logic [31:0] a,
                                           input logic [1:0] size, input logic uns);
        logic [63:0] v, mask;
        int bits;
        bits = 8 << size;
        v    = {32'b0, d} >> (8 * (a % 4));
        mask = (64'd1 << bits) - 64'd1;
        v    = v & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (armed) begin
            if (!bus_ok) chk("no_bus_req", o_mem_valid, 0);
            else if (o_mem_valid) begin
                chk("req_addr", o_mem_addr, exp_addr);
                chk("req_we", o_mem_we, exp_we);
                chk("req_wdata", o_mem_wdata, exp_wdata);
                chk("req_wstrb", o_mem_wstrb, exp_wstrb);
                chk("req_ready_low", o_ready, 0);
            end
            if (o_done) begin
                chk("done_single", prev_done, 0);
                chk("done_rdata", o_rdata, cur_rdata);
                chk("done_err", o_err, cur_err);
                chk("done_ready_low", o_ready, 0);
                hold_rdata = cur_rdata;
                hold_err   = cur_err;
                done_cnt++;
                done_cyc = cyc;
            end else if (o_ready) begin
                chk("hold_rdata", o_rdata, hold_rdata);
                chk("hold_err", o_err, hold_err);
            end
        end
        prev_done = o_done;
    end

    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int rd, input int vd, input logic withhold,
                          input logic [31:0] rdata, input logic berr, input int lat_exp);
        logic mis;
        int start, acc;
        mis       = m_mis(size, addr);
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_we    = we;
        exp_wdata = m_wdata(wdata, addr);
        exp_wstrb = we ? m_wstrb(size, addr) : 4'd0;
        cur_err   = mis ? 2'd1 : withhold ? 2'd3 : berr ? 2'd2 : 2'd0;
        cur_rdata = (cur_err != 2'd0 || we) ? 32'd0 : m_load(rdata, addr, size, uns);
        chk("idle_ready", o_ready, 1);
        i_valid = 1'b1; i_we = we; i_size = size; i_unsigned = uns;
        i_addr = addr; i_wdata = wdata;
        bus_ok = !mis;
        start  = done_cnt;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_wdata = 32'h5A5A_5A5A;
        i_addr  = 32'hFFFF_FFFF;
        acc = cyc;
        if (!mis) begin
            repeat (rd) begin @(posedge i_clk); #1; end
            i_mem_ready = 1'b1;
            @(posedge i_clk); #1;
            i_mem_ready = 1'b0;
            if (!withhold) begin
                repeat (vd) begin @(posedge i_clk); #1; end
                i_mem_rvalid = 1'b1; i_mem_rdata = rdata; i_mem_err = berr;
                @(posedge i_clk); #1;
                i_mem_rvalid = 1'b0; i_mem_err = 1'b0;
            end
        end
        for (int k = 0; k < 40 && done_cnt == start; k++) @(negedge i_clk);
        chk("done_seen", done_cnt - start, 1);
        chk("latency", done_cyc - acc + 1, lat_exp);
        @(posedge i_clk); #1;
        bus_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, want finish before 100us");
        $fatal(1);
    end

    initial begin
        int start;
        hold_rdata = '0; hold_err = '0; cur_rdata = '0; cur_err = '0;
        exp_addr = '0; exp_wdata = '0; exp_wstrb = '0; exp_we = 1'b0;

        chk("pin_lb", m_load(32'h80FF_FFFF, 32'h8000_0003, 2'd0, 1'b0), 32'hFFFF_FF80);
        chk("pin_lbu", m_load(32'h80FF_FFFF, 32'h8000_0003, 2'd0, 1'b1), 32'h0000_0080);
        chk("pin_sh_wdata", m_wdata(32'h1234_ABCD, 32'h8000_0002), 32'hABCD_0000);
        chk("pin_sh_wstrb", m_wstrb(2'd1, 32'h8000_0002), 4'b1100);
        chk("pin_lw_mis", m_mis(2'd2, 32'h8000_0002), 1);

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_mem_valid", o_mem_valid, 0);
        chk("rst_mem_we", o_mem_we, 0);
        chk("rst_wstrb", o_mem_wstrb, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_wdata", o_mem_wdata, 0);
        chk("rst_done", o_done, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_err", o_err, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        armed = 1'b1;

        //     we    size  uns   addr           wdata          rd vd hold  rdata          berr lat
        run_op(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0,          0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
        chk("lw_value", o_rdata, 32'hDEAD_BEEF);
        run_op(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0,          0, 0, 1'b0, 32'h80FF_FFFF, 1'b0, 3);
        chk("lb_value", o_rdata, 32'hFFFF_FF80);
        run_op(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0,          0, 0, 1'b0, 32'h80FF_FFFF, 1'b0, 3);
        chk("lbu_value", o_rdata, 32'h0000_0080);
        run_op(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h1234_ABCD,  3, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 6);
        run_op(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0,          0, 0, 1'b0, 32'h0,         1'b0, 1);
        chk("lw_mis_err", o_err, 2'd1);
        run_op(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0,          0, 1, 1'b0, 32'h5555_AAAA, 1'b1, 4);
        chk("berr_err", o_err, 2'd2);
        run_op(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0,          0, 0, 1'b1, 32'h0,         1'b0, 6);
        chk("tmo_err", o_err, 2'd3);
        run_op(1'b0, 2'd1, 1'b0, 32'h8000_0006, 32'h0,          0, 0, 1'b0, 32'h8001_1234, 1'b0, 3);
        run_op(1'b0, 2'd1, 1'b1, 32'h8000_0006, 32'h0,          0, 0, 1'b0, 32'h8001_1234, 1'b0, 3);
        run_op(1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00A5,  0, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 3);
        run_op(1'b1, 2'd2, 1'b0, 32'h8000_000C, 32'hCAFE_F00D,  1, 2, 1'b0, 32'h1234_5678, 1'b0, 6);
        run_op(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0,          0, 0, 1'b0, 32'h0,         1'b0, 1);
        run_op(1'b0, 2'd1, 1'b0, 32'h8000_0001, 32'h0,          0, 0, 1'b0, 32'h0,         1'b0, 1);
        run_op(1'b1, 2'd2, 1'b0, 32'h8000_0006, 32'h1111_2222,  0, 0, 1'b0, 32'h0,         1'b0, 1);
        run_op(1'b0, 2'd2, 1'b1, 32'h8000_0010, 32'h0,          0, 0, 1'b0, 32'h7654_3210, 1'b0, 3);

        // Reset while waiting for a response, then a stale response arrives.
        exp_addr = 32'h8000_0010; exp_we = 1'b0; exp_wdata = 32'h0; exp_wstrb = 4'd0;
        i_valid = 1'b1; i_we = 1'b0; i_size = 2'd2; i_unsigned = 1'b0;
        i_addr = 32'h8000_0010; i_wdata = 32'h0;
        bus_ok = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_mem_ready = 1'b1;
        @(posedge i_clk); #1;
        i_mem_ready = 1'b0;
        i_rst = 1'b1;
        hold_rdata = 32'd0; hold_err = 2'd0;
        bus_ok = 1'b0;
        start = done_cnt;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_wait_ready", o_ready, 1);
        chk("rst_wait_done", o_done, 0);
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1111_1111;
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            chk("late_rvalid_ready", o_ready, 1);
        end
        chk("late_rvalid_ignored", done_cnt - start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
